// File: rtl/qcpu_uart_fifo_if.sv
// CPU-side register/handshake bundle of the QCPU UART: frame config, FIFO push/pop and sticky flags.
interface qcpu_uart_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic [DIV_W-1:0]     divisor;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 two_stop;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_wr;
  logic                 tx_full;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_rd;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 err_clr;

  modport master (
    output divisor, parity_en, parity_odd, two_stop, tx_data, tx_wr, rx_rd, err_clr,
    input  tx_full, tx_busy, rx_data, rx_valid, frame_err, parity_err, overrun
  );

  modport slave (
    input  divisor, parity_en, parity_odd, two_stop, tx_data, tx_wr, rx_rd, err_clr,
    output tx_full, tx_busy, rx_data, rx_valid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/qcpu_uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, per-frame latched config, mid-bit RX sampling and sticky errors.
module qcpu_uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  qcpu_uart_fifo_if.slave        bus,
  output logic                   TX,
  input  logic                   RX
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty    = (tx_wp == tx_rp);
  assign bus.tx_full = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_push     = bus.tx_wr && !bus.tx_full;
  assign tx_head     = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wp[AW-1:0]] <= bus.tx_data;
        tx_wp <= tx_wp + 1'b1;
      end
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  state_t               tx_state, tx_state_n;
  logic [DIV_W-1:0]     tx_cnt, tx_div;
  logic [DATA_BITS-1:0] tx_sh;
  logic [BW-1:0]        tx_bitn;
  logic                 tx_pen, tx_two, tx_par, tx_stop2, tx_line, tx_line_n, tx_tick;

  assign tx_tick     = (tx_cnt == tx_div);
  assign TX          = tx_line;
  assign bus.tx_busy = !tx_empty || (tx_state != S_IDLE);

  // Last stop bit chains straight into the next START when the FIFO has data: no idle gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_line_n  = tx_line;
    tx_pop     = 1'b0;
    case (tx_state)
      S_IDLE:
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_state_n = S_START; tx_line_n = 1'b0;
        end
      S_START:
        if (tx_tick) begin
          tx_state_n = S_DATA; tx_line_n = tx_sh[0];
        end
      S_DATA:
        if (tx_tick) begin
          if (tx_bitn == LAST_BIT) begin
            tx_state_n = tx_pen ? S_PARITY : S_STOP;
            tx_line_n  = tx_pen ? tx_par : 1'b1;
          end else begin
            tx_line_n = tx_sh[1];
          end
        end
      S_PARITY:
        if (tx_tick) begin
          tx_state_n = S_STOP; tx_line_n = 1'b1;
        end
      S_STOP:
        if (tx_tick && (!tx_two || tx_stop2)) begin
          if (!tx_empty) begin
            tx_pop = 1'b1; tx_state_n = S_START; tx_line_n = 1'b0;
          end else begin
            tx_state_n = S_IDLE; tx_line_n = 1'b1;
          end
        end
      default: begin
        tx_state_n = S_IDLE; tx_line_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_line  <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_sh    <= '0;
      tx_bitn  <= '0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_par   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_line  <= tx_line_n;
      if (tx_pop) begin
        tx_sh    <= tx_head;
        tx_par   <= (^tx_head) ^ bus.parity_odd;
        tx_div   <= bus.divisor;
        tx_pen   <= bus.parity_en;
        tx_two   <= bus.two_stop;
        tx_cnt   <= '0;
        tx_bitn  <= '0;
        tx_stop2 <= 1'b0;
      end else if (tx_state != S_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= '0;
          if (tx_state == S_DATA) begin
            tx_sh   <= tx_sh >> 1;
            tx_bitn <= tx_bitn + 1'b1;
          end
          if (tx_state == S_STOP) tx_stop2 <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- RX FSM ----------------
  state_t               rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [DIV_W-1:0]     rx_cnt, rx_div;
  logic [DATA_BITS-1:0] rx_sh;
  logic [BW-1:0]        rx_bitn;
  logic                 rx_pen, rx_podd, rx_pbit;
  logic                 rx_tick, rx_half, rx_adv, rx_fin, rx_ferr, rx_perr, rx_push_req;

  assign rx_tick     = (rx_cnt == rx_div);
  assign rx_half     = (rx_cnt == (rx_div >> 1));
  assign rx_ferr     = rx_fin && !rx_s2;
  assign rx_perr     = rx_fin && rx_pen && (rx_pbit != ((^rx_sh) ^ rx_podd));
  assign rx_push_req = rx_fin && !rx_ferr && !rx_perr;

  // IDLE arms only on a synchronised 1->0 edge, so a held-low break yields a single frame.
  always_comb begin
    rx_state_n = rx_state;
    rx_adv     = 1'b0;
    rx_fin     = 1'b0;
    case (rx_state)
      S_IDLE:   if (rx_s3 && !rx_s2) rx_state_n = S_START;
      S_START:
        if (rx_half) begin
          rx_adv = 1'b1; rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (rx_tick) begin
          rx_adv = 1'b1;
          if (rx_bitn == LAST_BIT) rx_state_n = rx_pen ? S_PARITY : S_STOP;
        end
      S_PARITY:
        if (rx_tick) begin
          rx_adv = 1'b1; rx_state_n = S_STOP;
        end
      S_STOP:
        if (rx_tick) begin
          rx_adv = 1'b1; rx_fin = 1'b1; rx_state_n = S_IDLE;
        end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_sh    <= '0;
      rx_bitn  <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= (rx_state == S_IDLE || rx_adv) ? '0 : rx_cnt + 1'b1;
      if (rx_state == S_IDLE && rx_state_n == S_START) begin
        rx_div  <= bus.divisor;
        rx_pen  <= bus.parity_en;
        rx_podd <= bus.parity_odd;
        rx_bitn <= '0;
      end
      if (rx_state == S_DATA && rx_tick) begin
        rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
        rx_bitn <= rx_bitn + 1'b1;
      end
      if (rx_state == S_PARITY && rx_tick) rx_pbit <= rx_s2;
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp, rx_rp;
  logic                 rx_empty, rx_full, rx_pop, rx_store;

  assign rx_empty     = (rx_wp == rx_rp);
  assign rx_full      = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_pop       = bus.rx_rd && !rx_empty;
  assign rx_store     = rx_push_req && (!rx_full || rx_pop);
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp          <= '0;
      rx_rp          <= '0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (rx_store) begin
        rx_mem[rx_wp[AW-1:0]] <= rx_sh;
        rx_wp <= rx_wp + 1'b1;
      end
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      bus.frame_err  <= (bus.frame_err  && !bus.err_clr) || rx_ferr;
      bus.parity_err <= (bus.parity_err && !bus.err_clr) || rx_perr;
      bus.overrun    <= (bus.overrun    && !bus.err_clr) || (rx_push_req && rx_full && !rx_pop);
    end
  end
endmodule
